// File: rtl/hex_fmt_pkg.sv
// Shared constants and state encoding for the ASCII hex record transmitter.
package hex_fmt_pkg;

    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

    localparam int REC_LEN_LF    = 8;
    localparam int REC_LEN_NO_LF = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // Index of the final byte of a record; the LF slot is dropped when disabled.
    function automatic logic [2:0] last_idx(input bit with_lf);
        return with_lf ? 3'(REC_LEN_LF - 1) : 3'(REC_LEN_NO_LF - 1);
    endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit to lower-case ASCII hex digit converter.
module hex_nibble_ascii
    import hex_fmt_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_A_LC + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_record_tx.sv
// Serialises a (value, square) record as ASCII hex text: "vv sss \n".
// state | meaning
// IDLE  | waiting for a record, in_ready high
// SEND  | emitting record bytes, one per out_ready handshake
module hex_record_tx
    import hex_fmt_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR = 8'h20,
    parameter bit         WITH_LF  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [5:0]  in_value,
    input  logic [11:0] in_square,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] record_count
);

    localparam logic [2:0] LAST_IDX = last_idx(WITH_LF);

    tx_state_t   state, state_n;
    logic [2:0]  idx, idx_n;
    logic [5:0]  value_q, value_n;
    logic [11:0] square_q, square_n;
    logic [15:0] count_q, count_n;

    logic [3:0]  nibble;
    logic [7:0]  nibble_ascii;
    logic [7:0]  byte_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= 3'd0;
            value_q  <= 6'd0;
            square_q <= 12'd0;
            count_q  <= 16'd0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            value_q  <= value_n;
            square_q <= square_n;
            count_q  <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        value_n  = value_q;
        square_n = square_q;
        count_n  = count_q;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_n  = ST_SEND;
                    idx_n    = 3'd0;
                    value_n  = in_value;
                    square_n = in_square;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_n = ST_IDLE;
                        idx_n   = 3'd0;
                        count_n = count_q + 16'd1;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Single converter shared by all digit positions through the index mux.
    always_comb begin
        case (idx)
            3'd0:    nibble = {2'b00, value_q[5:4]};
            3'd1:    nibble = value_q[3:0];
            3'd3:    nibble = square_q[11:8];
            3'd4:    nibble = square_q[7:4];
            3'd5:    nibble = square_q[3:0];
            default: nibble = 4'h0;
        endcase
    end

    hex_nibble_ascii u_nibble (
        .nibble (nibble),
        .ascii  (nibble_ascii)
    );

    always_comb begin
        case (idx)
            3'd2, 3'd6: byte_sel = SEP_CHAR;
            3'd7:       byte_sel = ASCII_LF;
            default:    byte_sel = nibble_ascii;
        endcase
    end

    assign in_ready     = (state == ST_IDLE);
    assign out_valid    = (state == ST_SEND);
    assign busy         = (state == ST_SEND);
    assign out_byte     = out_valid ? byte_sel : 8'h00;
    assign record_count = count_q;

endmodule

// File: tb/tb_hex_record_tx.sv
// Directed bench for hex_record_tx: record table, stall, reset abort, no-LF and streaming cases.
module tb_hex_record_tx;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [5:0]  in_value;
    logic [11:0] in_square;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] record_count;

    logic        nl_in_valid;
    logic [5:0]  nl_in_value;
    logic [11:0] nl_in_square;
    logic        nl_in_ready;
    logic [7:0]  nl_out_byte;
    logic        nl_out_valid;
    logic        nl_out_ready;
    logic        nl_busy;
    logic [15:0] nl_record_count;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    hex_record_tx #(.SEP_CHAR(8'h20), .WITH_LF(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_value(in_value),
        .in_square(in_square), .in_ready(in_ready), .out_byte(out_byte),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .record_count(record_count)
    );

    hex_record_tx #(.SEP_CHAR(8'h20), .WITH_LF(1'b0)) dut_nl (
        .clk(clk), .reset(reset), .in_valid(nl_in_valid), .in_value(nl_in_value),
        .in_square(nl_in_square), .in_ready(nl_in_ready), .out_byte(nl_out_byte),
        .out_valid(nl_out_valid), .out_ready(nl_out_ready), .busy(nl_busy),
        .record_count(nl_record_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  value;
        logic [11:0] square;
        logic [63:0] bytes;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
    endfunction

    // Called just after a posedge; runs one full record on the WITH_LF=1 instance.
    task automatic send_record(input logic [5:0] v, input logic [11:0] s,
                               input logic [63:0] exp_bytes, input string name);
        in_valid  = 1'b1;
        in_value  = v;
        in_square = s;
        @(negedge clk);
        check({name, "_in_ready_idle"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("%s_valid%0d", name, k), out_valid, 1);
            check($sformatf("%s_byte%0d", name, k), out_byte, exp_bytes[63-8*k -: 8]);
            if (k == 0) check({name, "_in_ready_send"}, in_ready, 0);
            @(posedge clk); #1;
        end
        exp_count++;
        @(negedge clk);
        check({name, "_done_valid"}, out_valid, 0);
        check({name, "_done_byte"}, out_byte, 8'h00);
        check({name, "_done_ready"}, in_ready, 1);
        check({name, "_done_busy"}, busy, 0);
        check({name, "_count"}, record_count, exp_count);
        @(posedge clk); #1;
    endtask

    logic [7:0]  exp_stream [512];
    logic [63:0] nl_exp;

    initial begin
        vecs[0] = '{6'h05, 12'h019, 64'h30_35_20_30_31_39_20_0A};
        vecs[1] = '{6'h3F, 12'hF81, 64'h33_66_20_66_38_31_20_0A};
        vecs[2] = '{6'h2A, 12'h6E4, 64'h32_61_20_36_65_34_20_0A};
        vecs[3] = '{6'h00, 12'h000, 64'h30_30_20_30_30_30_20_0A};
        vecs[4] = '{6'h10, 12'h100, 64'h31_30_20_31_30_30_20_0A};

        reset = 1'b0;
        in_valid = 1'b0; in_value = '0; in_square = '0; out_ready = 1'b1;
        nl_in_valid = 1'b0; nl_in_value = '0; nl_in_square = '0; nl_out_ready = 1'b1;

        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_count", record_count, 0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // Reset abort while the fourth byte (index 3) is on the bus.
        in_valid = 1'b1; in_value = 6'h05; in_square = 12'h019;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("abort_pre_byte", out_byte, 8'h30);
        #1 reset = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_byte", out_byte, 8'h00);
        check("abort_in_ready", in_ready, 1);
        check("abort_count", record_count, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_after_valid", out_valid, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) send_record(vecs[i].value, vecs[i].square, vecs[i].bytes, $sformatf("vec%0d", i));

        // Stall at index 4 for three cycles with a competing upstream record present.
        in_valid = 1'b1; in_value = 6'h05; in_square = 12'h019;
        @(posedge clk); #1;
        in_value = 6'h3F; in_square = 12'hF81;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("stall_byte%0d", k), out_byte, vecs[0].bytes[63-8*k -: 8]);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d", c), out_byte, 8'h31);
            check($sformatf("stall_valid%0d", c), out_valid, 1);
            check($sformatf("stall_in_ready%0d", c), in_ready, 0);
            @(posedge clk); #1;
            if (c == 2) out_ready = 1'b1;
        end
        for (int k = 5; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("stall_byte%0d", k), out_byte, vecs[0].bytes[63-8*k -: 8]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        exp_count++;
        @(negedge clk);
        check("stall_done_ready", in_ready, 1);
        check("stall_count", record_count, exp_count);
        @(posedge clk); #1;

        // Seven-byte record on the no-LF instance.
        nl_exp = 64'h30_32_20_30_30_34_20_00;
        nl_in_valid = 1'b1; nl_in_value = 6'h02; nl_in_square = 12'h004;
        @(posedge clk); #1;
        nl_in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("nolf_valid%0d", k), nl_out_valid, 1);
            check($sformatf("nolf_byte%0d", k), nl_out_byte, nl_exp[63-8*k -: 8]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("nolf_idle_valid", nl_out_valid, 0);
        check("nolf_idle_ready", nl_in_ready, 1);
        check("nolf_count", nl_record_count, 1);
        @(posedge clk); #1;

        // 64 back-to-back records with in_valid held high.
        for (int i = 0; i < 64; i++) begin
            logic [11:0] sq;
            sq = 12'(i * i);
            exp_stream[8*i+0] = hexc({2'b00, 2'(i >> 4)});
            exp_stream[8*i+1] = hexc(4'(i));
            exp_stream[8*i+2] = 8'h20;
            exp_stream[8*i+3] = hexc(sq[11:8]);
            exp_stream[8*i+4] = hexc(sq[7:4]);
            exp_stream[8*i+5] = hexc(sq[3:0]);
            exp_stream[8*i+6] = 8'h20;
            exp_stream[8*i+7] = 8'h0A;
        end
        begin
            int acc = 0;
            int nbytes = 0;
            int cycles = 0;
            int idle_cycles = 0;
            int stream_bad = 0;
            logic will_acc;
            in_valid = 1'b1; in_value = 6'd0; in_square = 12'd0;
            while (nbytes < 512 && cycles < 2000) begin
                @(negedge clk);
                cycles++;
                if (out_valid) begin
                    if (out_byte !== exp_stream[nbytes]) begin
                        stream_bad++;
                        if (stream_bad <= 4)
                            check($sformatf("stream_byte%0d", nbytes), out_byte, exp_stream[nbytes]);
                    end
                    nbytes++;
                end
                if (in_ready) idle_cycles++;
                will_acc = in_ready && in_valid;
                @(posedge clk); #1;
                if (will_acc) begin
                    acc++;
                    if (acc < 64) begin
                        in_value  = 6'(acc);
                        in_square = 12'(acc * acc);
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            exp_count += 64;
            check("stream_mismatches", stream_bad, 0);
            check("stream_bytes", nbytes, 512);
            check("stream_cycles", cycles, 576);
            check("stream_idle_cycles", idle_cycles, 64);
            check("stream_accepted", acc, 64);
            check("stream_count", record_count, exp_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_record_tx.md
HEX_RECORD_TX -- requirements
Module: hex_record_tx

Interface
REQ-001 Parameter: SEP_CHAR, 8'h20, ASCII separator byte emitted after each hex field.
REQ-002 Parameter: WITH_LF, 1, when 1 append ASCII LF (8'h0A) after the second separator; when 0 omit it.
REQ-003 Port: clk  input  1  processing clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  upstream record (value, square) present.
REQ-006 Port: in_value  input  6  counter value from upstream stage.
REQ-007 Port: in_square  input  12  square of in_value from the square calculator.
REQ-008 Port: in_ready  output  1  block can accept a record this cycle.
REQ-009 Port: out_byte  output  8  ASCII character of the current record.
REQ-010 Port: out_valid  output  1  out_byte is valid.
REQ-011 Port: out_ready  input  1  downstream sink accepts out_byte this cycle.
REQ-012 Port: busy  output  1  a record is being emitted.
REQ-013 Port: record_count  output  16  number of records fully emitted.

Function
REQ-014 Record accepted on posedge where in_valid && in_ready; in_value and in_square captured into internal registers at that edge.
REQ-015 States: IDLE (in_ready=1, out_valid=0, busy=0) and SEND (in_ready=0, out_valid=1, busy=1).
REQ-016 IDLE -> SEND on acceptance; SEND -> IDLE on handshake of the last byte.
REQ-017 Byte order in SEND: hex(value[5:4] zero-extended), hex(value[3:0]), SEP_CHAR, hex(square[11:8]), hex(square[7:4]), hex(square[3:0]), SEP_CHAR, then LF if WITH_LF=1; 8 bytes per record (7 when WITH_LF=0).
REQ-018 Hex digit map: 0-9 -> 8'h30-8'h39, a-f -> 8'h61-8'h66 (lower case).
REQ-019 First byte valid in the cycle after acceptance (latency 1); byte index advances only on out_valid && out_ready.
REQ-020 While out_valid && !out_ready: out_byte, byte index and captured data held stable.
REQ-021 in_ready deasserted throughout SEND; upstream input ignored; no record dropped or overwritten.
REQ-022 After last-byte handshake, in_ready=1 in the next cycle; sustained throughput with out_ready=1 is one record per 9 cycles (8 with WITH_LF=0).
REQ-023 record_count increments by 1 on the last-byte handshake; wraps 16'hFFFF -> 16'h0000.
REQ-024 out_byte = 8'h00 whenever out_valid=0.

Reset
REQ-025 reset low forces immediately (asynchronously): state IDLE, byte index 0, captured data 0, out_byte 8'h00, out_valid 0, busy 0, record_count 0; in_ready = 1 while reset is low.
REQ-026 Reset asserted mid-record aborts the record: no further bytes, record_count not incremented.
REQ-027 After reset release, first acceptance possible on the first posedge with in_valid=1.

Structure
REQ-028 Shared package hex_fmt_pkg holds ASCII constants (8'h20, 8'h0A, 8'h30, 8'h61), the state encoding and the record-length constant.
REQ-029 One combinational sub-module hex_nibble_ascii (4-bit in, 8-bit ASCII out) instantiated once and driven by a byte-index mux.

Verification
REQ-030 value 6'h05, square 12'h019, out_ready=1 -> bytes 30 35 20 30 31 39 20 0A on 8 consecutive cycles, record_count=1.
REQ-031 value 6'h3F, square 12'hF81 -> bytes 33 66 20 66 38 31 20 0A; lower-case digits confirmed.
REQ-032 Same as REQ-030 with out_ready low for 3 cycles at byte 4 -> byte 8'h31 held for 4 cycles, then sequence resumes unchanged, in_ready stays 0.
REQ-033 Reset pulse during byte 3 of a record -> out_valid=0, out_byte=8'h00 at once; record_count unchanged; next record emitted complete.
REQ-034 WITH_LF=0, value 6'h02, square 12'h004 -> 30 32 20 30 30 34 20 (7 bytes), then IDLE.
REQ-035 64 back-to-back records (values 0..63, square=value*value, in_valid=1 continuously) -> 512 bytes, record_count=64, one idle cycle between records.
